// File: rtl/alu_seg7_if.sv
// rtl/alu_seg7_if.sv - capture/display bundle between ALU result source and seven-segment driver
interface alu_seg7_if;
    logic [31:0] alu_value;
    logic        alu_valid;
    logic        freeze;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic [31:0] shown_value;
    logic [7:0]  update_cnt;

    modport master (
        output alu_value, alu_valid, freeze,
        input  seg, dp, an, shown_value, update_cnt
    );

    modport slave (
        input  alu_value, alu_valid, freeze,
        output seg, dp, an, shown_value, update_cnt
    );
endinterface

// File: rtl/alu_seg7_display.sv
// rtl/alu_seg7_display.sv - holds captured ALU result and scans it onto an 8-digit hex display
module alu_seg7_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic      clk1,
    input  logic      rst_n,
    alu_seg7_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [7:0] AN_OFF  = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [31:0]   shown;
    logic [7:0]    cnt;

    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          blank;
    logic [6:0]    seg_raw;
    logic [7:0]    an_raw;
    logic          dp_raw;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        nib     = shown[{idx, 2'b00} +: 4];
        upper   = shown >> {idx, 2'b00};
        blank   = BLANK_LZ && (idx != 3'd0) && (upper == 32'd0);
        seg_raw = blank ? 7'h00 : hex_decode(nib);
        an_raw  = blank ? 8'h00 : (8'h01 << idx);
        dp_raw  = (idx == 3'd0) && bus.freeze;
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            presc   <= '0;
            idx     <= 3'd0;
            shown   <= 32'd0;
            cnt     <= 8'd0;
            bus.seg <= SEG_OFF;
            bus.an  <= AN_OFF;
            bus.dp  <= DP_OFF;
        end else begin
            bus.seg <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            bus.an  <= AN_ACTIVE_LOW  ? ~an_raw  : an_raw;
            bus.dp  <= SEG_ACTIVE_LOW ? ~dp_raw  : dp_raw;
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= idx + 3'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (bus.alu_valid && !bus.freeze) begin
                shown <= bus.alu_value;
                if (bus.alu_value != shown)
                    cnt <= cnt + 8'd1;
            end
        end
    end

    assign bus.shown_value = shown;
    assign bus.update_cnt  = cnt;
endmodule

// File: tb/tb_alu_seg7_display.sv
// tb/tb_alu_seg7_display.sv - randomized self-checking bench against a cycle-level display model
module tb_alu_seg7_display;
    localparam int DIV = 2;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    alu_seg7_if bus();

    alu_seg7_display #(
        .REFRESH_DIV(DIV), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_idx, m_presc, m_cnt;
    logic [31:0] m_shown;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [55:0] got, expv;

    // One clock edge of the display as described in words: show the digit the scan
    // pointer sits on, then advance the scan and apply any capture.
    task automatic tick(input logic r, input logic [31:0] v, input logic vl, input logic fz);
        logic [3:0]  nib;
        logic [31:0] up;
        rst_n = r;
        bus.alu_value = v;
        bus.alu_valid = vl;
        bus.freeze = fz;
        @(posedge clk1);
        if (!r) begin
            m_idx = 0; m_presc = 0; m_shown = 0; m_cnt = 0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            up  = m_shown >> (4 * m_idx);
            nib = up[3:0];
            if (m_idx > 0 && up == 0) begin
                e_an = 8'hFF; e_seg = 7'h7F;
            end else begin
                e_an = ~(8'(1) << m_idx); e_seg = ~hex_tab[nib];
            end
            e_dp = !(m_idx == 0 && fz);
            m_presc = m_presc + 1;
            if (m_presc == DIV) begin
                m_presc = 0;
                m_idx = (m_idx + 1) % 8;
            end
            if (vl && !fz) begin
                if (v != m_shown) m_cnt = (m_cnt + 1) % 256;
                m_shown = v;
            end
        end
        #1;
        got  = {bus.an, bus.seg, bus.dp, bus.shown_value, bus.update_cnt};
        expv = {e_an, e_seg, e_dp, m_shown, 8'(m_cnt)};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (got !== {8'hFF, 7'h7F, 1'b1, 32'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", got, {8'hFF, 7'h7F, 1'b1, 32'd0, 8'd0});
        end
    endtask

    task automatic test_single_capture();
        int seen5 = 0, seenA = 0;
        tick(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 32'd0, 1'b0, 1'b0);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL single_scan cyc=%0d got=%h want=%h", i, got, expv);
            end
            if (bus.an == 8'hFE && bus.seg == ~7'h6D) seen5++;
            if (bus.an == 8'hFD && bus.seg == ~7'h77) seenA++;
        end
        checks++;
        if (bus.shown_value !== 32'hA5 || bus.update_cnt !== 8'd1 || seen5 == 0 || seenA == 0) begin
            errors++;
            $display("FAIL single_digits shown=%h cnt=%0d seen5=%0d seenA=%0d want A5/1/>0/>0",
                     bus.shown_value, bus.update_cnt, seen5, seenA);
        end
    endtask

    task automatic test_repeat_capture();
        int seen1 = 0;
        tick(1'b1, 32'h1234_ABCD, 1'b1, 1'b0);
        tick(1'b1, 32'h1234_ABCD, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) begin
            tick(1'b1, 32'd0, 1'b0, 1'b0);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL repeat_scan cyc=%0d got=%h want=%h", i, got, expv);
            end
            if (bus.an == 8'h7F && bus.seg == ~7'h06) seen1++;
        end
        checks++;
        if (bus.update_cnt !== 8'd2 || seen1 == 0) begin
            errors++;
            $display("FAIL repeat_count cnt=%0d seen_digit7=%0d want 2/>0", bus.update_cnt, seen1);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] before_v = bus.shown_value;
        logic [7:0]  before_c = bus.update_cnt;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 32'hFFFF_FFFF, 1'(i % 2), 1'b1);
            checks++;
            if (got !== expv || (bus.dp == 1'b0) != (bus.an == 8'hFE && i > 0)) begin
                errors++;
                $display("FAIL freeze cyc=%0d got=%h want=%h", i, got, expv);
            end
        end
        checks++;
        if (bus.shown_value !== before_v || bus.update_cnt !== before_c) begin
            errors++;
            $display("FAIL freeze_hold shown=%h cnt=%0d want %h/%0d",
                     bus.shown_value, bus.update_cnt, before_v, before_c);
        end
        tick(1'b1, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        int start = m_cnt;
        for (int i = 0; i < 256; i++) tick(1'b1, (i % 2 == 0) ? 32'd1 : 32'd2, 1'b1, 1'b0);
        checks++;
        if (got !== expv || int'(bus.update_cnt) != start) begin
            errors++;
            $display("FAIL wrap cnt=%0d want %0d got=%h want=%h", bus.update_cnt, start, got, expv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] v;
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v = v >> (4 * $urandom_range(0, 7));
            tick(1'b1, v, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, got, expv);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int guard = 0;
        while (m_idx != 5 && guard < 32) begin
            tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (m_idx != 5) begin
            errors++;
            $display("FAIL midreset_reach idx=%0d want 5", m_idx);
        end
        tick(1'b0, 32'h5555_5555, 1'b1, 1'b0);
        checks++;
        if (bus.an !== 8'hFF || bus.shown_value !== 32'd0 || bus.update_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state an=%h shown=%h cnt=%0d want FF/0/0",
                     bus.an, bus.shown_value, bus.update_cnt);
        end
        tick(1'b1, 32'd0, 1'b0, 1'b0);
        checks++;
        if (bus.an !== 8'hFE || got !== expv) begin
            errors++;
            $display("FAIL midreset_restart an=%h want FE got=%h want=%h", bus.an, got, expv);
        end
    endtask

    initial begin
        bus.alu_value = 32'd0;
        bus.alu_valid = 1'b0;
        bus.freeze = 1'b0;
        test_reset();
        test_single_capture();
        test_repeat_capture();
        test_freeze();
        test_wrap();
        test_random();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
